// File: rtl/pipeline_mon_pkg.sv
// rtl/pipeline_mon_pkg.sv - shared types and helpers for the pipeline performance monitor
package pipeline_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } mon_state_t;

  localparam int SEL_CYCLE = 0;

  // Select width needed to address the cycle counter plus every event channel.
  function automatic int min_sel_w(input int num_evt);
    return $clog2(num_evt + 1);
  endfunction

endpackage

// File: rtl/pipeline_perf_monitor_sat_counter.sv
// rtl/pipeline_perf_monitor_sat_counter.sv - saturating up-counter with clear and overflow pulse
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         ovf
);

  logic at_max;

  assign at_max = &value;
  // An increment attempt at all-ones is the overflow event; a clear in the same cycle wins.
  assign ovf    = inc && at_max && !clr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc && !at_max) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// rtl/pipeline_perf_monitor.sv - cycle/event monitor with limit halt, sticky overflow and snapshot bank
module pipeline_perf_monitor
  import pipeline_mon_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               snap_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic               rd_bank_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               running_o,
  output logic               halt_o,
  output logic [NUM_EVT:0]   ovf_o
);

  localparam int NCH = NUM_EVT + 1;

  if (SEL_W < min_sel_w(NUM_EVT)) begin : g_sel_w_check
    $error("pipeline_perf_monitor: SEL_W too small for NUM_EVT");
  end

  mon_state_t       state, state_nx;
  logic             in_run;
  logic [NCH-1:0]   inc;
  logic [NCH-1:0]   ovf_pulse;
  logic [NCH-1:0]   ovf_q;
  logic [CNT_W-1:0] live   [NCH];
  logic [CNT_W-1:0] shadow [NCH];
  logic [CNT_W-1:0] cycle_next;
  logic [CNT_W-1:0] rd_mux;

  assign in_run = (state == ST_RUN);
  assign inc    = {evt_i & {NUM_EVT{in_run}}, in_run};

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear_i),
      .inc   (inc[g]),
      .value (live[g]),
      .ovf   (ovf_pulse[g])
    );
  end

  // Value the cycle counter will hold after this edge if still running.
  assign cycle_next = (&live[SEL_CYCLE]) ? live[SEL_CYCLE] : live[SEL_CYCLE] + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (clear_i) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start_i) state_nx = ST_RUN;
        ST_RUN: begin
          // Reaching the limit wins over a pause on the same edge.
          if ((limit_i != '0) && (cycle_next == limit_i)) begin
            state_nx = ST_HALT;
          end else if (!start_i) begin
            state_nx = ST_IDLE;
          end
        end
        ST_HALT: state_nx = ST_HALT;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_q | ovf_pulse;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int k = 0; k < NCH; k++) shadow[k] <= '0;
    end else if (snap_i) begin
      for (int k = 0; k < NCH; k++) shadow[k] <= live[k];
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_mux = rd_bank_i ? shadow[k] : live[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= rd_mux;
    end
  end

  assign cycle_o   = live[SEL_CYCLE];
  assign running_o = (state == ST_RUN);
  assign halt_o    = (state == ST_HALT);
  assign ovf_o     = ovf_q;

endmodule
